proc_control: RTL and testbench

Instruction sequencer for the base processor datapath. Holds the 9-bit instruction register, decodes each instruction, and steps through T0–T3. In each step it drives the register-file load enables (`r_in`), the bus-driver selects (`r_out`, `g_out`, `din_out`) and the ALU controls (`a_in`, `g_in`, `add_sub`). It also signals instruction completion on `done`. It sits between the instruction source on `din` and the `WIDTH`-bit register bank / bus multiplexer.

---
 rtl/proc_control.sv | 126 ++++++++++++
 tb/tb_proc_control.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_control.sv
// rtl/proc_control.sv - instruction sequencer for the base processor datapath
module proc_control #(
  parameter int DIN_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic [DIN_WIDTH-1:0] din,
  output logic                 ir_in,
  output logic [7:0]           r_in,
  output logic [7:0]           r_out,
  output logic                 a_in,
  output logic                 g_in,
  output logic                 g_out,
  output logic                 din_out,
  output logic                 add_sub,
  output logic                 done,
  output logic                 busy
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  state_t     state;
  state_t     state_next;
  logic [8:0] ir;
  logic [2:0] opcode;
  logic [7:0] x_sel;
  logic [7:0] y_sel;
  logic       unused_din;

  assign opcode = ir[8:6];
  assign x_sel  = 8'b1 << ir[5:3];
  assign y_sel  = 8'b1 << ir[2:0];

  // Only din[8:0] carries the instruction; upper bits are operand-only.
  assign unused_din = ^(din >> 9);

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= T0;
    else       state <= state_next;
  end

  // Instruction register loads only on an accepted run in T0, so it stays stable through T1-T3.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   ir <= 9'd0;
    else if (state == T0 && run) ir <= din[8:0];
  end

  // Next-state and control strobes; everything is forced low while reset is held.
  always_comb begin
    state_next = state;
    ir_in      = 1'b0;
    r_in       = 8'd0;
    r_out      = 8'd0;
    a_in       = 1'b0;
    g_in       = 1'b0;
    g_out      = 1'b0;
    din_out    = 1'b0;
    add_sub    = 1'b0;
    done       = 1'b0;
    busy       = (state != T0);
    case (state)
      T0: begin
        ir_in = run;
        if (run) state_next = T1;
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            r_out      = y_sel;
            r_in       = x_sel;
            done       = 1'b1;
            state_next = T0;
          end
          OP_MVI: begin
            din_out    = 1'b1;
            r_in       = x_sel;
            done       = 1'b1;
            state_next = T0;
          end
          OP_ADD, OP_SUB: begin
            r_out      = x_sel;
            a_in       = 1'b1;
            state_next = T2;
          end
          default: begin
            done       = 1'b1;
            state_next = T0;
          end
        endcase
      end
      T2: begin
        r_out      = y_sel;
        g_in       = 1'b1;
        add_sub    = ir[6];
        state_next = T3;
      end
      T3: begin
        g_out      = 1'b1;
        r_in       = x_sel;
        done       = 1'b1;
        state_next = T0;
      end
      default: state_next = T0;
    endcase
    if (reset) begin
      ir_in   = 1'b0;
      r_in    = 8'd0;
      r_out   = 8'd0;
      a_in    = 1'b0;
      g_in    = 1'b0;
      g_out   = 1'b0;
      din_out = 1'b0;
      add_sub = 1'b0;
      done    = 1'b0;
      busy    = 1'b0;
    end
  end

endmodule

// File: tb/tb_proc_control.sv
// tb/tb_proc_control.sv - directed self-checking bench for proc_control
module tb_proc_control;

  logic        clock;
  logic        reset;
  logic        run;
  logic [15:0] din;
  logic        ir_in;
  logic [7:0]  r_in;
  logic [7:0]  r_out;
  logic        a_in;
  logic        g_in;
  logic        g_out;
  logic        din_out;
  logic        add_sub;
  logic        done;
  logic        busy;
  logic [23:0] obs;

  int checks = 0;
  int fails  = 0;

  proc_control #(.DIN_WIDTH(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .din     (din),
    .ir_in   (ir_in),
    .r_in    (r_in),
    .r_out   (r_out),
    .a_in    (a_in),
    .g_in    (g_in),
    .g_out   (g_out),
    .din_out (din_out),
    .add_sub (add_sub),
    .done    (done),
    .busy    (busy)
  );

  // obs layout: {ir_in, r_in, r_out, a_in, g_in, g_out, din_out, add_sub, done, busy}
  assign obs = {ir_in, r_in, r_out, a_in, g_in, g_out, din_out, add_sub, done, busy};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [23:0] ex(input logic i, input logic [7:0] ri, input logic [7:0] ro,
                                     input logic a, input logic g, input logic go, input logic d,
                                     input logic s, input logic dn, input logic b);
    return {i, ri, ro, a, g, go, d, s, dn, b};
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if (obs !== 24'd0) begin
      $display("FAIL reset_outputs_t0: got %h expected %h", obs, 24'd0);
      fails++;
    end
    @(negedge clock);
    #1;
    checks++;
    if (obs !== 24'd0) begin
      $display("FAIL reset_outputs_held: got %h expected %h", obs, 24'd0);
      fails++;
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0)) begin
      $display("FAIL reset_release_ir_in: got %h expected %h", obs, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
      fails++;
    end
    // IR = 9'o123 decodes as mvi R2 in T1
    @(negedge clock);
    run = 1'b0;
    din = 16'h0000;
    #1;
    checks++;
    if (obs !== ex(0, 8'h04, 8'h00, 0, 0, 0, 1, 0, 1, 1)) begin
      $display("FAIL reset_first_ir: got %h expected %h", obs, ex(0, 8'h04, 8'h00, 0, 0, 0, 1, 0, 1, 1));
      fails++;
    end
    @(negedge clock);
    #1;
    checks++;
    if (obs !== 24'd0) begin
      $display("FAIL reset_back_idle: got %h expected %h", obs, 24'd0);
      fails++;
    end
  endtask

  task automatic test_mvi();
    logic        r [3];
    logic [15:0] d [3];
    logic [23:0] e [3];
    r = '{1'b1, 1'b0, 1'b0};
    d = '{16'o120, 16'h00AB, 16'h0000};
    e = '{ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0),
          ex(0, 8'h04, 8'h00, 0, 0, 0, 1, 0, 1, 1),
          24'd0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      run = r[i];
      din = d[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL mvi step %0d: got %h expected %h", i, obs, e[i]);
        fails++;
      end
    end
  endtask

  task automatic test_mv();
    logic        r [3];
    logic [15:0] d [3];
    logic [23:0] e [3];
    r = '{1'b1, 1'b0, 1'b0};
    d = '{16'o052, 16'o777, 16'h0000};
    e = '{ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0),
          ex(0, 8'h20, 8'h04, 0, 0, 0, 0, 0, 1, 1),
          24'd0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      run = r[i];
      din = d[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL mv step %0d: got %h expected %h", i, obs, e[i]);
        fails++;
      end
    end
  endtask

  task automatic test_sub();
    logic        r [5];
    logic [15:0] d [5];
    logic [23:0] e [5];
    // din changes after T0 must not disturb decode
    r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    d = '{16'o334, 16'o052, 16'o001, 16'hFFFF, 16'h0000};
    e = '{ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0),
          ex(0, 8'h00, 8'h08, 1, 0, 0, 0, 0, 0, 1),
          ex(0, 8'h00, 8'h10, 0, 1, 0, 0, 1, 0, 1),
          ex(0, 8'h08, 8'h00, 0, 0, 1, 0, 0, 1, 1),
          24'd0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      run = r[i];
      din = d[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL sub step %0d: got %h expected %h", i, obs, e[i]);
        fails++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        r [7];
    logic [15:0] d [7];
    logic [23:0] e [7];
    int          done_at [$];
    r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    d = '{16'o201, 16'o070, 16'o070, 16'o070, 16'o070, 16'o000, 16'o000};
    e = '{ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0),
          ex(0, 8'h00, 8'h01, 1, 0, 0, 0, 0, 0, 1),
          ex(0, 8'h00, 8'h02, 0, 1, 0, 0, 0, 0, 1),
          ex(0, 8'h01, 8'h00, 0, 0, 1, 0, 0, 1, 1),
          ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0),
          ex(0, 8'h80, 8'h01, 0, 0, 0, 0, 0, 1, 1),
          24'd0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      run = r[i];
      din = d[i];
      #1;
      if (done === 1'b1) done_at.push_back(i);
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL b2b step %0d: got %h expected %h", i, obs, e[i]);
        fails++;
      end
    end
    checks++;
    if (done_at.size() != 2 || done_at[0] != 3 || done_at[1] - done_at[0] != 2) begin
      $display("FAIL b2b_done_spacing: got %0d pulses first at %0d expected 2 pulses at 3 and 5",
               done_at.size(), (done_at.size() > 0) ? done_at[0] : -1);
      fails++;
    end
  endtask

  task automatic test_reset_mid();
    logic        r [3];
    logic [15:0] d [3];
    logic [23:0] e [3];
    r = '{1'b1, 1'b0, 1'b0};
    d = '{16'o266, 16'o000, 16'o000};
    e = '{ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0),
          ex(0, 8'h00, 8'h40, 1, 0, 0, 0, 0, 0, 1),
          ex(0, 8'h00, 8'h40, 0, 1, 0, 0, 0, 0, 1)};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      run = r[i];
      din = d[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL reset_mid step %0d: got %h expected %h", i, obs, e[i]);
        fails++;
      end
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== 24'd0) begin
      $display("FAIL reset_mid_immediate: got %h expected %h", obs, 24'd0);
      fails++;
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs !== 24'd0) begin
        $display("FAIL reset_mid_quiet %0d: got %h expected %h", i, obs, 24'd0);
        fails++;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_nop();
    logic        r [3];
    logic [15:0] d [3];
    logic [23:0] e [3];
    r = '{1'b1, 1'b0, 1'b0};
    d = '{16'o512, 16'o000, 16'o000};
    e = '{ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0),
          ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1),
          24'd0};
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clock);
      run = r[i];
      din = d[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        $display("FAIL nop step %0d: got %h expected %h", i, obs, e[i]);
        fails++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b1;
    din   = 16'o123;
    test_reset();
    test_mvi();
    test_mv();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    test_nop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
